// File: rtl/rand_walk_pkg.sv
// Shared definitions for the rand_walk block: FSM state encoding and the
// default parameter values (position bounds, sample period, FIFO depth).
package rand_walk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_UPDATE = 2'd2,
    ST_PUSH   = 2'd3
  } rw_state_e;

  localparam int signed RW_POS_MIN_DEF = -100;
  localparam int signed RW_POS_MAX_DEF = 100;
  localparam int        RW_DIV_DEF     = 4;
  localparam int        RW_DEPTH_DEF   = 4;

endpackage

// File: rtl/rw_fifo.sv
// rw_fifo: small synchronous FIFO holding walk positions.
// A pop is only honoured when the FIFO holds data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle. clear_i flushes the
// FIFO and overrides any concurrent push/pop. rdata_o reads as 0 when empty.
module rw_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array: written on an accepted push, never reset (gated by count).
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rand_walk.sv
// rand_walk: bounded random walk sampled every DIV enabled cycles.
// A tick starts IDLE->SAMPLE->UPDATE->PUSH; the new position lands in an
// output FIFO three cycles after the tick.
// Output handshake: an entry transfers on any cycle where out_valid and
// out_ready are both high; out_pos shows the head and is 0 when empty.
// Build option: define RAND_WALK_WRAP_EN to wrap out-of-range positions
// around the [POS_MIN, POS_MAX] range instead of clamping them.
module rand_walk
  import rand_walk_pkg::*;
#(
  parameter int        DIV     = RW_DIV_DEF,
  parameter int signed POS_MIN = RW_POS_MIN_DEF,
  parameter int signed POS_MAX = RW_POS_MAX_DEF,
  parameter int        DEPTH   = RW_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] randNum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pos,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  dbg_state_o
);

  localparam logic [7:0]         DIV_LAST = 8'(DIV - 1);
  localparam logic signed [32:0] MIN33    = 33'(POS_MIN);
  localparam logic signed [32:0] MAX33    = 33'(POS_MAX);

  rw_state_e          state_q, state_d;
  logic [7:0]         tick_cnt_q, tick_cnt_d;
  logic signed [31:0] pos_q, pos_d;
  logic signed [31:0] step_q, step_d;
  logic [7:0]         drop_q, drop_d;
  logic signed [32:0] sum;
  logic signed [31:0] bounded;
  logic               tick;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign tick        = enable && (tick_cnt_q == DIV_LAST);
  assign fifo_push   = (state_q == ST_PUSH);
  assign fifo_pop    = out_ready && !fifo_empty;
  assign out_valid   = !fifo_empty;
  assign drop_cnt    = drop_q;
  assign dbg_state_o = state_q;

  // Sample-period counter: advances only while enabled, wraps at DIV-1.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (enable) begin
      tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
    end
  end

  // Sequencer: a tick is only accepted in IDLE, the rest of the walk is fixed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_PUSH;
      ST_PUSH:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // New position at 33 bits so pos+step never overflows, then bounded.
  always_comb begin
    sum     = 33'(pos_q) + 33'(step_q);
    bounded = sum[31:0];
`ifdef RAND_WALK_WRAP_EN
    if (sum > MAX33) begin
      bounded = 32'(MIN33 + (sum - MAX33) - 33'sd1);
    end else if (sum < MIN33) begin
      bounded = 32'(MAX33 - (MIN33 - sum) + 33'sd1);
    end
`else
    if (sum > MAX33) begin
      bounded = POS_MAX;
    end else if (sum < MIN33) begin
      bounded = POS_MIN;
    end
`endif
  end

  // Datapath next-state: step capture, position update, drop counting.
  always_comb begin
    step_d = step_q;
    pos_d  = pos_q;
    drop_d = drop_q;
    if (state_q == ST_SAMPLE) step_d = randNum;
    if (state_q == ST_UPDATE) pos_d = bounded;
    if (fifo_push && fifo_full && !fifo_pop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    if (clear) begin
      pos_d  = '0;
      drop_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      pos_q      <= '0;
      step_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      drop_q     <= drop_d;
    end
  end

  rw_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (clear),
    .push_i  (fifo_push),
    .wdata_i (pos_q),
    .pop_i   (fifo_pop),
    .rdata_o (out_pos),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_rand_walk.sv
// Bench for rand_walk: directed walks, FIFO full/drop cases, clear and reset
// mid-sequence, then a randomized run. A walk model predicts each queued
// position; a monitor pops and compares whenever the DUT hands one out.
module tb_rand_walk;
  import rand_walk_pkg::*;

  localparam int DIV     = 4;
  localparam int DEPTH   = 4;
  localparam int POS_MIN = -100;
  localparam int POS_MAX = 100;

  logic        clock = 1'b0;
  logic        reset, enable, clear, out_ready;
  logic [31:0] randNum;
  logic        out_valid;
  logic [31:0] out_pos;
  logic [7:0]  drop_cnt;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  // walk model
  int m_cyc, m_t0, m_en_cnt, m_occ, m_drops, m_pos, m_step;
  bit m_busy, m_was_busy, m_tick, m_pop, m_pushed;

  // monitor observations
  int          pop_cnt = 0;
  logic [31:0] dut_last_pop = '0;

  rand_walk #(
    .DIV(DIV), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .DEPTH(DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .randNum     (randNum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pos     (out_pos),
    .drop_cnt    (drop_cnt),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    end
  endtask

  function automatic int walk_bound(input int v);
`ifdef RAND_WALK_WRAP_EN
    if (v > POS_MAX) return POS_MIN + (v - POS_MAX - 1);
    if (v < POS_MIN) return POS_MAX - (POS_MIN - v - 1);
    return v;
`else
    if (v > POS_MAX) return POS_MAX;
    if (v < POS_MIN) return POS_MIN;
    return v;
`endif
  endfunction

  function automatic void model_init();
    m_cyc    = 0;
    m_t0     = 0;
    m_en_cnt = 0;
    m_occ    = 0;
    m_drops  = 0;
    m_pos    = 0;
    m_step   = 0;
    m_busy   = 1'b0;
    exp_q.delete();
  endfunction

  // Reference walk: a tick on enabled cycle DIV-1 (mod DIV) starts a step;
  // the step is taken one cycle later, applied two cycles later and the new
  // position is queued three cycles after the tick unless the queue is full.
  always @(posedge clock or negedge reset) begin
    if (!reset || clear) begin
      model_init();
    end else begin
      m_was_busy = m_busy;
      m_tick     = enable && (m_en_cnt == DIV - 1);
      if (enable) m_en_cnt = (m_en_cnt + 1) % DIV;
      m_pop    = out_ready && (m_occ > 0);
      m_pushed = 1'b0;
      if (m_busy && m_cyc == m_t0 + 1) m_step = $signed(randNum);
      if (m_busy && m_cyc == m_t0 + 2) m_pos = walk_bound(m_pos + m_step);
      if (m_busy && m_cyc == m_t0 + 3) begin
        if (m_occ < DEPTH || m_pop) begin
          exp_q.push_back(32'(m_pos));
          m_pushed = 1'b1;
        end else if (m_drops < 255) begin
          m_drops++;
        end
        m_busy = 1'b0;
      end
      m_occ = m_occ + int'(m_pushed) - int'(m_pop);
      if (m_tick && !m_was_busy) begin
        m_busy = 1'b1;
        m_t0   = m_cyc;
      end
      m_cyc++;
    end
  end

  // Monitor / scoreboard: compares outputs mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      chk("out_valid", {31'b0, out_valid}, 32'(m_occ > 0));
      chk("drop_cnt", {24'b0, drop_cnt}, 32'(m_drops));
      if (!out_valid) chk("out_pos_empty", out_pos, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", {31'b0, out_valid}, 32'd0);
        end else begin
          chk("out_pos", out_pos, exp_q.pop_front());
        end
        dut_last_pop = out_pos;
        pop_cnt++;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n;
    n = 0;
    while (dbg_state !== s && n < 40) begin
      step(1);
      n++;
    end
    if (dbg_state !== s) chk({"timeout_", name}, {30'b0, dbg_state}, {30'b0, s});
  endtask

  task automatic run_ticks(input int ticks, input int step_val);
    randNum = 32'(step_val);
    enable  = 1'b1;
    step(ticks * DIV);
    enable  = 1'b0;
    step(8);
  endtask

  int pops_before;

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; out_ready = 1'b1; randNum = '0;
    step(3);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pos", out_pos, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    reset = 1'b1;

    // +3 constant: 3, 6, 9
    run_ticks(3, 3);
    chk("p3_pops", 32'(pop_cnt), 32'd3);
    chk("p3_last", dut_last_pop, 32'd9);

    // +7 from 0: 98 after 14 ticks, then clamp to 100 or wrap to -96
    do_clear();
    run_ticks(14, 7);
    chk("p7_98", dut_last_pop, 32'd98);
    run_ticks(1, 7);
`ifdef RAND_WALK_WRAP_EN
    chk("p7_wrap", dut_last_pop, -32'sd96);
`else
    chk("p7_sat", dut_last_pop, 32'd100);
    run_ticks(5, 7);
    chk("p7_hold", dut_last_pop, 32'd100);
`endif

    // -7 from 0 toward POS_MIN
    do_clear();
    run_ticks(20, -7);
`ifndef RAND_WALK_WRAP_EN
    chk("m7_floor", dut_last_pop, -32'sd100);
`endif

    // consumer stalled: 6 ticks into a 4-deep FIFO, two dropped
    do_clear();
    out_ready = 1'b0;
    run_ticks(6, 1);
    chk("full_drop", {24'b0, drop_cnt}, 32'd2);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    // push and pop in the same cycle on a full FIFO
    pops_before = pop_cnt;
    randNum = 32'd1;
    enable  = 1'b1;
    wait_state(ST_PUSH, "push");
    out_ready = 1'b1;
    enable    = 1'b0;
    step(1);
    out_ready = 1'b0;
    step(2);
    chk("pp_drop", {24'b0, drop_cnt}, 32'd2);
    chk("pp_pops", 32'(pop_cnt - pops_before), 32'd1);
    out_ready = 1'b1;
    step(8);
    chk("drain_pops", 32'(pop_cnt - pops_before), 32'd5);
    chk("drain_last", dut_last_pop, 32'd7);

    // clear during UPDATE with two entries queued
    do_clear();
    out_ready = 1'b0;
    randNum   = 32'd2;
    enable    = 1'b1;
    step(2 * DIV + 3);
    wait_state(ST_UPDATE, "update");
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_valid", {31'b0, out_valid}, 32'd0);
    chk("clr_drop", {24'b0, drop_cnt}, 32'd0);
    chk("clr_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    out_ready = 1'b1;
    run_ticks(1, 5);
    chk("clr_pos0", dut_last_pop, 32'd5);

    // reset in the middle of a sequence
    randNum = 32'd4;
    enable  = 1'b1;
    wait_state(ST_SAMPLE, "sample");
    reset = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    chk("mrst_pos", out_pos, 32'd0);
    step(2);
    reset = 1'b1;
    run_ticks(1, 4);
    chk("mrst_first", dut_last_pop, 32'd4);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      randNum   = 32'($urandom_range(0, 14)) - 32'd7;
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 199) == 0);
      step(1);
    end
    clear     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    step(12);
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
